// File: rtl/bias_pkg.sv
// Shared definitions for the bias fetch path: fetch FSM states and default geometry.
package bias_pkg;

    localparam int BIAS_LANES = 4;
    localparam int BIAS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } bias_state_e;

endpackage

// File: rtl/bias_fetch_unit.sv
// Fetches one LANES-wide bias vector from an external one-cycle-latency ROM and
// presents it on a valid/ready handshake.
module bias_fetch_unit
    import bias_pkg::*;
#(
    parameter int  LANES = BIAS_LANES,
    parameter int  WIDTH = BIAS_WIDTH,
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [AW-1:0]          first_ch,
    input  logic [AW:0]            num_ch,
    output logic                   busy,
    output logic                   rom_read_enable,
    output logic [AW-1:0]          rom_addr,
    input  logic [WIDTH-1:0]       rom_bias,
    output logic [LANES*WIDTH-1:0] bias_vec,
    output logic                   bias_valid,
    input  logic                   bias_ready
);

    localparam int            LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int            SW   = AW + 2;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);

    bias_state_e state_q, state_d;

    logic [AW-1:0] base_q, first_q;
    logic [AW:0]   num_q;
    logic [LW-1:0] lane_q;

    // Read issued last cycle, whose data is on rom_bias this cycle.
    logic          cap_pend_q, cap_en_q;
    logic [LW-1:0] cap_lane_q;

    logic [LANES-1:0][WIDTH-1:0] stage_q, vec_q, vec_d;

    logic [SW-1:0] ch_idx, addr_sum;
    logic          lane_en;

    always_comb begin
        ch_idx   = SW'(first_q) + SW'(lane_q);
        lane_en  = ch_idx < SW'(num_q);
        addr_sum = SW'(base_q) + ch_idx;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (lane_q == LAST) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (bias_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy            = (state_q != IDLE);
    assign bias_valid      = (state_q == HOLD);
    assign rom_read_enable = (state_q == ISSUE) && lane_en;
    assign rom_addr        = rom_read_enable ? AW'(addr_sum % SW'(DEPTH)) : '0;
    assign bias_vec        = vec_q;

    // Lanes past the layer's channel count are forced to zero instead of captured.
    always_comb begin
        vec_d = stage_q;
        if (cap_pend_q) vec_d[cap_lane_q] = cap_en_q ? rom_bias : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            first_q    <= '0;
            num_q      <= '0;
            lane_q     <= '0;
            cap_pend_q <= 1'b0;
            cap_en_q   <= 1'b0;
            cap_lane_q <= '0;
            stage_q    <= '0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= vec_d;
            cap_pend_q <= (state_q == ISSUE);
            cap_en_q   <= rom_read_enable;
            cap_lane_q <= lane_q;
            if (state_q == IDLE && start) begin
                base_q  <= base_addr;
                first_q <= first_ch;
                num_q   <= num_ch;
                lane_q  <= '0;
            end
            if (state_q == ISSUE) lane_q <= (lane_q == LAST) ? '0 : lane_q + 1'b1;
            // Output vector only moves when the final lane lands, so it is stable outside HOLD.
            if (state_q == DRAIN) vec_q <= vec_d;
        end
    end

endmodule

// File: tb/tb_bias_fetch_unit.sv
// Bench for bias_fetch_unit: directed table, handshake/reset sequences, random fetches.
module tb_bias_fetch_unit;

    localparam int LANES = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int VW    = LANES * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] first_ch = '0;
    logic [AW:0]   num_ch = '0;
    logic          busy;
    logic          rom_read_enable;
    logic [AW-1:0] rom_addr;
    logic [WIDTH-1:0] rom_bias = '0;
    logic [VW-1:0] bias_vec;
    logic          bias_valid;
    logic          bias_ready = 1'b0;

    logic [WIDTH-1:0] rom [DEPTH];

    int n_vec  = 0;
    int n_miss = 0;

    bias_fetch_unit #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .first_ch(first_ch), .num_ch(num_ch), .busy(busy),
        .rom_read_enable(rom_read_enable), .rom_addr(rom_addr), .rom_bias(rom_bias),
        .bias_vec(bias_vec), .bias_valid(bias_valid), .bias_ready(bias_ready)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM; data goes stale when not strobed.
    always @(posedge clk) if (rom_read_enable) rom_bias <= rom[rom_addr];

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] first;
        logic [AW:0]   num;
        logic [VW-1:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] model_vec(input int b, input int f, input int n);
        logic [VW-1:0] v = '0;
        for (int k = 0; k < LANES; k++)
            if (f + k < n) v[k*WIDTH +: WIDTH] = rom[(b + f + k) % DEPTH];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch with cycle-exact checks; optional start pokes during HOLD and at handshake.
    task automatic fetch(input int b, input int f, input int n, input logic [VW-1:0] exp,
                         input int hold, input bit poke);
        base_addr = AW'(b); first_ch = AW'(f); num_ch = (AW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            bit en = (f + k < n);
            chk($sformatf("rd_en lane%0d", k), VW'(rom_read_enable), VW'(en));
            chk($sformatf("addr lane%0d", k), VW'(rom_addr), en ? VW'((b + f + k) % DEPTH) : '0);
            chk("busy issue", VW'(busy), VW'(1));
            tick();
        end
        chk("valid drain", VW'({bias_valid, rom_read_enable}), '0);
        tick();
        chk("valid hold", VW'(bias_valid), VW'(1));
        chk("vec", bias_vec, exp);
        for (int c = 0; c < hold; c++) begin
            if (poke) begin
                start = 1'b1; base_addr = 8'hAA; first_ch = 8'h00; num_ch = 9'd200;
            end
            tick();
            chk("hold valid", VW'({busy, bias_valid, rom_read_enable}), VW'(3'b110));
            chk("hold vec", bias_vec, exp);
        end
        bias_ready = 1'b1;
        tick();
        bias_ready = 1'b0;
        start = 1'b0;
        chk("after hs", VW'({busy, bias_valid}), '0);
        chk("vec after hs", bias_vec, exp);
        tick();
        chk("idle busy", VW'(busy), '0);
    endtask

    vec_t tbl [4];

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = 32'h100 + i;
        tbl[0] = '{8'd16,  8'd4, 9'd16, {32'h117, 32'h116, 32'h115, 32'h114}};
        tbl[1] = '{8'd16,  8'd4, 9'd6,  {32'h0,   32'h0,   32'h115, 32'h114}};
        tbl[2] = '{8'd254, 8'd0, 9'd8,  {32'h101, 32'h100, 32'h1FF, 32'h1FE}};
        tbl[3] = '{8'd16,  8'd8, 9'd3,  '0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", VW'({busy, rom_read_enable, rom_addr, bias_valid}), '0);
        chk("reset vec", bias_vec, '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            fetch(int'(tbl[i].base), int'(tbl[i].first), int'(tbl[i].num), tbl[i].exp, 0, 1'b0);

        // Long stall with start pokes while holding.
        fetch(16, 4, 16, tbl[0].exp, 10, 1'b1);

        // Reset during ISSUE, then start held across a reset edge.
        base_addr = 8'd16; first_ch = 8'd4; num_ch = 9'd16; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid rst outs", VW'({busy, rom_read_enable, rom_addr, bias_valid}), '0);
        chk("mid rst vec", bias_vec, '0);
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("no start in rst", VW'(busy), '0);
        fetch(254, 0, 8, tbl[2].exp, 2, 1'b0);

        // Random contents and requests against the reference model.
        for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
        for (int t = 0; t < 40; t++) begin
            int b = $urandom_range(0, DEPTH - 1);
            int f = $urandom_range(0, DEPTH - 1);
            int n = ($urandom_range(0, 1) == 0) ? $urandom_range(0, DEPTH)
                                                : f + $urandom_range(0, LANES + 1);
            if (n > DEPTH) n = DEPTH;
            fetch(b, f, n, model_vec(b, f, n), $urandom_range(0, 3), 1'(($urandom_range(0, 1))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
